// File: rtl/centroid_pkg.sv
// -----------------------------------------------------------------------------
// centroid_pkg
// Shared definitions for the red-object centroid tracker:
//   - RGB444 field bit positions of the 12-bit pixel word
//   - default image geometry and coordinate widths
//   - accumulator / pixel-count width derivation
//   - tracker FSM state encoding
// Optional feature macro used by the top level: CENTROID_BBOX_EN.
// -----------------------------------------------------------------------------
package centroid_pkg;

  // Pixel word layout: {R[11:8], G[7:4], B[3:0]}
  localparam int PIX_W = 12;
  localparam int R_HI  = 11;
  localparam int R_LO  = 8;
  localparam int G_HI  = 7;
  localparam int G_LO  = 4;
  localparam int B_HI  = 3;
  localparam int B_LO  = 0;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  // Coordinate widths are fixed by the overlay interface.
  localparam int X_W = 10;
  localparam int Y_W = 9;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Coordinate sums: every pixel of a frame at the largest coordinate bounds
  // the total, so size for max(w,h) * w * h (28 bits at 640x480).
  function automatic int calc_sum_w(input int w, input int h);
    return $clog2(max_int(w, h) * w * h);
  endfunction

  // Pixel count must hold w*h itself (19 bits at 640x480).
  function automatic int calc_cnt_w(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV    = 2'd1,
    ST_UPDATE = 2'd2
  } track_state_t;

endpackage

// File: rtl/serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// Restoring unsigned divider, one quotient bit per clock, W iterations.
// A start pulse loads the operands; the next W clocks each retire one bit.
// done is high during the final iteration cycle, so a controller sampling it
// steps forward on the same edge that lands the last quotient bit.
// A zero divisor yields an all-ones quotient; callers screen that case.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load dividend/divisor and begin (one-cycle pulse)
//   dividend    W-bit numerator
//   divisor     DW-bit denominator (DW < W+1)
//   done        high in the cycle of the last iteration
//   quotient    low QW bits of the truncating quotient
// -----------------------------------------------------------------------------
module serial_divider #(
  parameter int W  = 28,
  parameter int DW = 19,
  parameter int QW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [DW-1:0] rem;
  logic [W-1:0]  quo;
  logic [DW-1:0] dvs;
  logic [CW-1:0] iter;
  logic          busy;

  logic [DW:0]   shifted;
  logic [DW:0]   dvs_ext;
  logic          fits;

  // The remainder stays below the divisor, so DW bits plus the shifted-in
  // dividend bit are enough for the trial subtraction.
  always_comb begin
    shifted = {rem, quo[W-1]};
    dvs_ext = {1'b0, dvs};
    fits    = (shifted >= dvs_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
      iter <= CW'(W);
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= DW'(fits ? (shifted - dvs_ext) : shifted);
      quo  <= {quo[W-2:0], fits};
      iter <= iter - CW'(1);
      if (iter == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign done     = busy && (iter == CW'(1));
  assign quotient = quo[QW-1:0];

endmodule

// File: rtl/red_centroid_tracker.sv
// -----------------------------------------------------------------------------
// red_centroid_tracker
// Observes an RGB444 pixel stream, classifies valid pixels as red, sums the
// coordinates of red pixels over a frame and, after the end-of-frame pixel,
// divides the sums by the red-pixel count to produce a centroid for the
// crosshair overlay of the following frame. The stream is not modified.
//
// Optional feature: define CENTROID_BBOX_EN to add a red-pixel bounding box
// (o_bbox_xmin/xmax/ymin/ymax) that updates together with the centroid.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_data_valid         pixel qualifier
//   i_data               pixel {R,G,B} nibbles
//   i_end_frame          last pixel of frame (only with i_data_valid)
//   o_centroid_x/_y      centroid column / row
//   o_red_object_valid   last completed frame had >= MIN_PIXELS red pixels
//   o_centroid_update    one-cycle pulse when the outputs are refreshed
// -----------------------------------------------------------------------------
module red_centroid_tracker
  import centroid_pkg::*;
#(
  parameter int         IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int         IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter logic [3:0] RED_MIN    = 4'd10,
  parameter logic [3:0] GB_MAX     = 4'd5,
  parameter int         MIN_PIXELS = 20
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_data_valid,
  input  logic [PIX_W-1:0] i_data,
  input  logic             i_end_frame,
  output logic [X_W-1:0]   o_centroid_x,
  output logic [Y_W-1:0]   o_centroid_y,
  output logic             o_red_object_valid,
`ifdef CENTROID_BBOX_EN
  output logic [X_W-1:0]   o_bbox_xmin,
  output logic [X_W-1:0]   o_bbox_xmax,
  output logic [Y_W-1:0]   o_bbox_ymin,
  output logic [Y_W-1:0]   o_bbox_ymax,
`endif
  output logic             o_centroid_update
);

  localparam int SUM_W = calc_sum_w(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_W = calc_cnt_w(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  function automatic logic is_red(input logic [PIX_W-1:0] pix);
    return (pix[R_HI:R_LO] >= RED_MIN) &&
           (pix[G_HI:G_LO] <= GB_MAX)  &&
           (pix[B_HI:B_LO] <= GB_MAX);
  endfunction

  track_state_t state;

  logic [X_W-1:0]   x_pos;
  logic [Y_W-1:0]   y_pos;
  logic [SUM_W-1:0] sum_x, sum_y;
  logic [CNT_W-1:0] pix_cnt;

  logic [SUM_W-1:0] snap_x, snap_y;
  logic [CNT_W-1:0] snap_cnt;

  logic             red_p0, eof_p0;
  logic [SUM_W-1:0] acc_x_p0, acc_y_p0;
  logic [CNT_W-1:0] acc_cnt_p0;

  logic             div_start;
  logic             done_x, done_y, div_done;
  logic [X_W-1:0]   quot_x;
  logic [Y_W-1:0]   quot_y;

  // ---- stage p0: classify the pixel and form running totals including it
  always_comb begin
    red_p0     = i_data_valid && is_red(i_data);
    eof_p0     = i_data_valid && i_end_frame;
    acc_x_p0   = sum_x + (red_p0 ? SUM_W'(x_pos) : '0);
    acc_y_p0   = sum_y + (red_p0 ? SUM_W'(y_pos) : '0);
    acc_cnt_p0 = pix_cnt + (red_p0 ? CNT_W'(1) : '0);
  end

  // Raster position and accumulators. The end-of-frame pixel always clears
  // the accumulators, even when its totals are dropped because a division
  // is still in flight, so the next frame starts clean.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_pos   <= '0;
      y_pos   <= '0;
      sum_x   <= '0;
      sum_y   <= '0;
      pix_cnt <= '0;
    end else if (i_data_valid) begin
      if (i_end_frame) begin
        x_pos   <= '0;
        y_pos   <= '0;
        sum_x   <= '0;
        sum_y   <= '0;
        pix_cnt <= '0;
      end else begin
        sum_x   <= acc_x_p0;
        sum_y   <= acc_y_p0;
        pix_cnt <= acc_cnt_p0;
        if (x_pos == X_W'(IMG_WIDTH - 1)) begin
          x_pos <= '0;
          y_pos <= (y_pos == Y_W'(IMG_HEIGHT - 1)) ? '0 : y_pos + Y_W'(1);
        end else begin
          x_pos <= x_pos + X_W'(1);
        end
      end
    end
  end

`ifdef CENTROID_BBOX_EN
  logic [X_W-1:0] bx_min, bx_max, nx_min_p0, nx_max_p0;
  logic [Y_W-1:0] by_min, by_max, ny_min_p0, ny_max_p0;
  logic [X_W-1:0] snap_bx_min, snap_bx_max;
  logic [Y_W-1:0] snap_by_min, snap_by_max;
  logic           first_p0;

  // The first red pixel of a frame seeds all four bounds.
  always_comb begin
    first_p0  = (pix_cnt == '0);
    nx_min_p0 = bx_min;
    nx_max_p0 = bx_max;
    ny_min_p0 = by_min;
    ny_max_p0 = by_max;
    if (red_p0) begin
      if (first_p0 || (x_pos < bx_min)) nx_min_p0 = x_pos;
      if (first_p0 || (x_pos > bx_max)) nx_max_p0 = x_pos;
      if (first_p0 || (y_pos < by_min)) ny_min_p0 = y_pos;
      if (first_p0 || (y_pos > by_max)) ny_max_p0 = y_pos;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bx_min <= '0;
      bx_max <= '0;
      by_min <= '0;
      by_max <= '0;
    end else if (i_data_valid) begin
      if (i_end_frame) begin
        bx_min <= '0;
        bx_max <= '0;
        by_min <= '0;
        by_max <= '0;
      end else begin
        bx_min <= nx_min_p0;
        bx_max <= nx_max_p0;
        by_min <= ny_min_p0;
        by_max <= ny_max_p0;
      end
    end
  end
`endif

  serial_divider #(.W(SUM_W), .DW(CNT_W), .QW(X_W)) u_div_x (
    .clk      (i_clk),
    .rst_n    (i_rstn),
    .start    (div_start),
    .dividend (snap_x),
    .divisor  (snap_cnt),
    .done     (done_x),
    .quotient (quot_x)
  );

  serial_divider #(.W(SUM_W), .DW(CNT_W), .QW(Y_W)) u_div_y (
    .clk      (i_clk),
    .rst_n    (i_rstn),
    .start    (div_start),
    .dividend (snap_y),
    .divisor  (snap_cnt),
    .done     (done_y),
    .quotient (quot_y)
  );

  assign div_done = done_x && done_y;

  // ---- stage p1: snapshot, serial division, result update
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state              <= ST_IDLE;
      snap_x             <= '0;
      snap_y             <= '0;
      snap_cnt           <= '0;
      div_start          <= 1'b0;
      o_centroid_x       <= '0;
      o_centroid_y       <= '0;
      o_red_object_valid <= 1'b0;
      o_centroid_update  <= 1'b0;
`ifdef CENTROID_BBOX_EN
      snap_bx_min        <= '0;
      snap_bx_max        <= '0;
      snap_by_min        <= '0;
      snap_by_max        <= '0;
      o_bbox_xmin        <= '0;
      o_bbox_xmax        <= '0;
      o_bbox_ymin        <= '0;
      o_bbox_ymax        <= '0;
`endif
    end else begin
      div_start         <= 1'b0;
      o_centroid_update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (eof_p0) begin
            snap_x    <= acc_x_p0;
            snap_y    <= acc_y_p0;
            snap_cnt  <= acc_cnt_p0;
            div_start <= 1'b1;
            state     <= ST_DIV;
`ifdef CENTROID_BBOX_EN
            snap_bx_min <= nx_min_p0;
            snap_bx_max <= nx_max_p0;
            snap_by_min <= ny_min_p0;
            snap_by_max <= ny_max_p0;
`endif
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          // The count check also screens out the zero-divisor quotient.
          if (snap_cnt >= MIN_CNT) begin
            o_centroid_x       <= quot_x;
            o_centroid_y       <= quot_y;
            o_red_object_valid <= 1'b1;
`ifdef CENTROID_BBOX_EN
            o_bbox_xmin        <= snap_bx_min;
            o_bbox_xmax        <= snap_bx_max;
            o_bbox_ymin        <= snap_by_min;
            o_bbox_ymax        <= snap_by_max;
`endif
          end else begin
            o_red_object_valid <= 1'b0;
          end
          o_centroid_update <= 1'b1;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_centroid_tracker.sv
// Directed bench: one full-size tracker (640x480, MIN_PIXELS=1) and two
// reduced-geometry trackers (64x32, MIN_PIXELS=1 and 20) share one stimulus.
// The reduced geometry keeps whole-frame wrap tests short; its SUM_W is 17,
// so its update latency is 19 cycles versus 30 for the full-size instance.
module tb_red_centroid_tracker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dvalid;
  logic [11:0] data;
  logic        eof;

  logic [9:0] big_x, a_x, b_x;
  logic [8:0] big_y, a_y, b_y;
  logic       big_v, a_v, b_v;
  logic       big_u, a_u, b_u;

  always #5 clk = ~clk;

  red_centroid_tracker #(.MIN_PIXELS(1)) dut_big (
    .i_clk(clk), .i_rstn(rstn), .i_data_valid(dvalid), .i_data(data),
    .i_end_frame(eof), .o_centroid_x(big_x), .o_centroid_y(big_y),
    .o_red_object_valid(big_v), .o_centroid_update(big_u));

  red_centroid_tracker #(.IMG_WIDTH(64), .IMG_HEIGHT(32), .MIN_PIXELS(1)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_data_valid(dvalid), .i_data(data),
    .i_end_frame(eof), .o_centroid_x(a_x), .o_centroid_y(a_y),
    .o_red_object_valid(a_v), .o_centroid_update(a_u));

  red_centroid_tracker #(.IMG_WIDTH(64), .IMG_HEIGHT(32), .MIN_PIXELS(20)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_data_valid(dvalid), .i_data(data),
    .i_end_frame(eof), .o_centroid_x(b_x), .o_centroid_y(b_y),
    .o_red_object_valid(b_v), .o_centroid_update(b_u));

  int n_checks = 0;
  int n_errors = 0;
  int lat_big, lat_a, lat_b;
  int np_big, np_a, np_b;

  logic [11:0] nonred [5] = '{12'h000, 12'h955, 12'hA65, 12'hA56, 12'h0F0};
  localparam logic [11:0] RED0 = 12'hF00;
  localparam logic [11:0] RED1 = 12'hA55;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Red-pixel placement by frame mode and valid-pixel index.
  //   1: single pixel at index 32100 = (100,50) at 640 wide, (36,21) at 64x32
  //   2: 10x10 block x 30..39, y 10..19 at 64 wide
  //   3: (0,0) after one full 64x32 wrap, then (63,31)
  //   4: every pixel red
  function automatic bit pick_red(input int mode, input int i);
    case (mode)
      1: return i == 32100;
      2: return (i % 64) >= 30 && (i % 64) <= 39 && (i / 64) >= 10 && (i / 64) <= 19;
      3: return i == 2048 || i == 4095;
      4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_frame(input int mode, input int npix, input bit eof_last);
    for (int i = 0; i < npix; i++) begin
      // Modes 2 and 4 interleave invalid red end-of-frame cycles, which must be ignored.
      if ((mode == 2 || mode == 4) && (i % 7 == 3)) begin
        @(negedge clk);
        dvalid = 1'b0; eof = 1'b1; data = RED0;
      end
      @(negedge clk);
      dvalid = 1'b1;
      eof    = eof_last && (i == npix - 1);
      data   = pick_red(mode, i) ? ((i % 2 == 1) ? RED1 : RED0) : nonred[i % 5];
    end
  endtask

  // The first edge is the one sampling the last driven pixel (k = 0).
  task automatic watch(input int budget);
    lat_big = -1; lat_a = -1; lat_b = -1;
    np_big = 0; np_a = 0; np_b = 0;
    @(posedge clk); #1;
    dvalid = 1'b0; eof = 1'b0; data = 12'h000;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (big_u) begin np_big++; if (lat_big < 0) lat_big = k; end
      if (a_u)   begin np_a++;   if (lat_a < 0)   lat_a = k;   end
      if (b_u)   begin np_b++;   if (lat_b < 0)   lat_b = k;   end
    end
  endtask

  task automatic check_a(input string tag, input int x, input int y, input int v);
    check_val({tag, "_a_x"}, a_x, x);
    check_val({tag, "_a_y"}, a_y, y);
    check_val({tag, "_a_v"}, a_v, v);
  endtask

  task automatic check_b(input string tag, input int x, input int y, input int v);
    check_val({tag, "_b_x"}, b_x, x);
    check_val({tag, "_b_y"}, b_y, y);
    check_val({tag, "_b_v"}, b_v, v);
  endtask

  initial begin
    rstn = 1'b0; dvalid = 1'b0; eof = 1'b0; data = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_big_x", big_x, 0);
    check_val("rst_big_v", big_v, 0);
    check_val("rst_big_u", big_u, 0);
    check_a("rst", 0, 0, 0);
    check_val("rst_a_u", a_u, 0);
    @(negedge clk); rstn = 1'b1;

    // Single red pixel, also the same-cycle red + end-of-frame case.
    send_frame(1, 32101, 1'b1);
    watch(40);
    check_val("t1_big_lat", lat_big, 30);
    check_val("t1_big_np", np_big, 1);
    check_val("t1_big_x", big_x, 100);
    check_val("t1_big_y", big_y, 50);
    check_val("t1_big_v", big_v, 1);
    check_val("t1_a_lat", lat_a, 19);
    check_a("t1", 36, 21, 1);
    check_b("t1", 0, 0, 0);
    check_val("t1_b_np", np_b, 1);

    // Block frame, then a second end-of-frame 5 cycles later that is dropped.
    send_frame(2, 1256, 1'b1);
    @(posedge clk); #1;
    dvalid = 1'b0; eof = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    dvalid = 1'b1; eof = 1'b1; data = RED0;
    watch(40);
    check_val("t2_a_lat", lat_a, 14);
    check_val("t2_a_np", np_a, 1);
    check_val("t2_big_lat", lat_big, 25);
    check_val("t2_big_np", np_big, 1);
    check_a("t2", 34, 14, 1);
    check_b("t2", 34, 14, 1);

    // All-black frame: invalid, centroid held, pulse still produced.
    send_frame(0, 100, 1'b1);
    watch(40);
    check_val("t3_a_lat", lat_a, 19);
    check_val("t3_b_np", np_b, 1);
    check_a("t3", 34, 14, 0);
    check_b("t3", 34, 14, 0);

    // Opposite corners after a full raster wrap.
    send_frame(3, 4096, 1'b1);
    watch(40);
    check_val("t4_a_np", np_a, 1);
    check_a("t4", 31, 15, 1);
    check_b("t4", 34, 14, 0);

    // 19 and 20 red pixels straddle the MIN_PIXELS=20 threshold.
    send_frame(4, 19, 1'b1);
    watch(40);
    check_a("t5", 9, 0, 1);
    check_b("t5", 34, 14, 0);
    send_frame(4, 20, 1'b1);
    watch(40);
    check_a("t6", 9, 0, 1);
    check_b("t6", 9, 0, 1);

    // Reset while dividing: outputs clear at once and no pulse follows.
    send_frame(2, 1256, 1'b1);
    @(posedge clk); #1;
    dvalid = 1'b0; eof = 1'b0;
    repeat (8) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_a("t7", 0, 0, 0);
    check_b("t7", 0, 0, 0);
    check_val("t7_a_u", a_u, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    watch(40);
    check_val("t7_a_np", np_a, 0);
    check_val("t7_big_np", np_big, 0);

    // Reset mid-frame: partial red data must be discarded.
    send_frame(2, 700, 1'b0);
    #2 rstn = 1'b0;
    #1;
    dvalid = 1'b0;
    check_val("t8_a_v", a_v, 0);
    check_val("t8_big_x", big_x, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    send_frame(4, 20, 1'b1);
    watch(40);
    check_val("t9_a_lat", lat_a, 19);
    check_a("t9", 9, 0, 1);
    check_b("t9", 9, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
